// File: rtl/twiddle_rom_8pt.sv
// Registered binary32 twiddle-factor table W8^k = e^(-j*2*pi*k/8), k = 0..3.
// Define TWIDDLE_INV_EN to add the inv port, which registers the conjugate W8^-k instead.
module twiddle_rom_8pt (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  addr,
`ifdef TWIDDLE_INV_EN
   input  logic        inv,
`endif
   output logic [31:0] w_real,
   output logic [31:0] w_imag
);

   localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
   localparam logic [31:0] FP_ONE      = 32'h3F80_0000;
   localparam logic [31:0] FP_NEG_ONE  = 32'hBF80_0000;
   localparam logic [31:0] FP_RT_HALF  = 32'h3F35_04F3;
   localparam logic [31:0] FP_NEG_RTH  = 32'hBF35_04F3;

   logic [31:0] fwd_real;
   logic [31:0] fwd_imag;
   logic [31:0] imag_sel;
   logic        conj;

   always_comb begin
      fwd_real = FP_ZERO;
      fwd_imag = FP_ZERO;
      case (addr)
         2'd0: begin fwd_real = FP_ONE;     fwd_imag = FP_ZERO;    end
         2'd1: begin fwd_real = FP_RT_HALF; fwd_imag = FP_NEG_RTH; end
         2'd2: begin fwd_real = FP_ZERO;    fwd_imag = FP_NEG_ONE; end
         default: begin fwd_real = FP_NEG_RTH; fwd_imag = FP_NEG_RTH; end
      endcase
   end

`ifdef TWIDDLE_INV_EN
   assign conj = inv;
`else
   assign conj = 1'b0;
`endif

   // Only the sign bit moves on conjugation; a zero imaginary part must stay +0.0.
   always_comb begin
      imag_sel = fwd_imag;
      if (conj && (fwd_imag[30:0] != 31'd0)) begin
         imag_sel[31] = ~fwd_imag[31];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_real <= FP_ZERO;
         w_imag <= FP_ZERO;
      end else begin
         w_real <= fwd_real;
         w_imag <= imag_sel;
      end
   end

endmodule

// File: tb/tb_twiddle_rom_8pt.sv
// Self-checking bench for twiddle_rom_8pt: directed sequences plus random traffic checked
// against a trigonometric reference model.
module tb_twiddle_rom_8pt;

   localparam real PI = 3.14159265358979323846;
`ifdef TWIDDLE_INV_EN
   localparam bit INV_SUP = 1'b1;
`else
   localparam bit INV_SUP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [1:0]  addr;
`ifdef TWIDDLE_INV_EN
   logic        inv;
`endif
   logic [31:0] w_real;
   logic [31:0] w_imag;

   int n_chk;
   int n_err;

   twiddle_rom_8pt dut (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr),
`ifdef TWIDDLE_INV_EN
      .inv    (inv),
`endif
      .w_real (w_real),
      .w_imag (w_imag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Map an exact trig value in {0, +-1/sqrt2, +-1} to its binary32 pattern; zero is +0.0.
   function automatic logic [31:0] fp_of(input real x);
      real         ax;
      logic [31:0] mag;
      ax = (x < 0.0) ? -x : x;
      if (ax < 1.0e-6) return 32'h0000_0000;
      mag = (ax > 0.99) ? 32'h3F80_0000 : 32'h3F35_04F3;
      return {(x < 0.0), mag[30:0]};
   endfunction

   function automatic logic [63:0] model(input int k, input bit conj);
      real ang;
      real im;
      ang = 2.0 * PI * real'(k) / 8.0;
      im  = conj ? $sin(ang) : -$sin(ang);
      return {fp_of($cos(ang)), fp_of(im)};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Apply one set of inputs, clock once, compare both registered outputs.
   task automatic step(input string tag, input int k, input bit r, input bit v);
      logic [63:0] e;
      bit          conj;
      conj = v & INV_SUP;
      addr = 2'(k);
      rst  = r;
`ifdef TWIDDLE_INV_EN
      inv  = v;
`endif
      e = r ? 64'd0 : model(k, conj);
      @(posedge clk);
      #1;
      check({tag, "_re"}, w_real, e[63:32]);
      check({tag, "_im"}, w_imag, e[31:0]);
   endtask

   int seq_rev [4] = '{3, 2, 1, 0};
   int seq_rnd [4] = '{2, 0, 3, 1};

   initial begin
      n_chk = 0;
      n_err = 0;
      addr  = 2'd1;
      rst   = 1'b1;
`ifdef TWIDDLE_INV_EN
      inv   = 1'b0;
`endif

      step("rst0", 1, 1'b1, 1'b0);
      step("rst1", 3, 1'b1, 1'b0);
      step("first", 0, 1'b0, 1'b0);

      step("idx1", 1, 1'b0, 1'b0);
      check("idx1_lit_re", w_real, 32'h3F35_04F3);
      check("idx1_lit_im", w_imag, 32'hBF35_04F3);
      step("idx2", 2, 1'b0, 1'b0);
      check("idx2_lit_re", w_real, 32'h0000_0000);
      check("idx2_lit_im", w_imag, 32'hBF80_0000);
      check("w2_im_sign", 32'(w_imag[31]), 32'd1);
      step("idx3", 3, 1'b0, 1'b0);
      check("idx3_lit_re", w_real, 32'hBF35_04F3);
      check("idx3_lit_im", w_imag, 32'hBF35_04F3);

      for (int i = 0; i < 4; i++) step("fwd_seq", i, 1'b0, 1'b0);
      check("fwd_last_re", w_real, 32'hBF35_04F3);
      for (int i = 0; i < 4; i++) step("rev_seq", seq_rev[i], 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step("rnd_seq", seq_rnd[i], 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step("mod_seq", i % 4, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++) begin
         step("hold0", 0, 1'b0, 1'b0);
         check("hold0_lit_re", w_real, 32'h3F80_0000);
         check("hold0_lit_im", w_imag, 32'h0000_0000);
      end

      step("mid_a", 1, 1'b0, 1'b0);
      step("mid_b", 2, 1'b0, 1'b0);
      step("mid_rst", 3, 1'b1, 1'b0);
      check("mid_rst_lit", w_real | w_imag, 32'h0000_0000);
      step("mid_c", 3, 1'b0, 1'b0);
      step("mid_d", 0, 1'b0, 1'b0);

      if (INV_SUP) begin
         step("inv2", 2, 1'b0, 1'b1);
         check("inv2_lit_im", w_imag, 32'h3F80_0000);
         step("inv0", 0, 1'b0, 1'b1);
         check("inv0_lit_im", w_imag, 32'h0000_0000);
         step("inv1", 1, 1'b0, 1'b1);
         step("inv3", 3, 1'b0, 1'b1);
         for (int i = 0; i < 4; i++) step("inv_off", i, 1'b0, 1'b0);
      end

      for (int i = 0; i < 400; i++) begin
         step("rand", int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
              bit'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
